// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: detects mispredicts, redirects fetch, discards wrong-path work,
// and queues predictor updates with performance counters.
module branch_resolution_unit #(
   parameter int unsigned UPD_FIFO_DEPTH = 4,
   parameter int unsigned FLUSH_CYCLES   = 2,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 res_valid_i,
   output logic                 res_ready_o,
   input  logic [31:0]          res_pc_i,
   input  logic                 res_is_branch_i,
   input  logic                 res_pred_taken_i,
   input  logic [31:0]          res_pred_target_i,
   input  logic                 res_actual_taken_i,
   input  logic [31:0]          res_actual_target_i,
   output logic                 redirect_o,
   output logic [31:0]          redirect_pc_o,
   input  logic                 upd_stall_i,
   output logic                 update_o,
   output logic [31:0]          update_pc_o,
   output logic                 actual_taken_o,
   output logic [31:0]          actual_target_o,
   output logic                 is_branch_o,
   input  logic                 cnt_clear_i,
   output logic [CNT_WIDTH-1:0] branch_cnt_o,
   output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

   localparam int unsigned PtrW = (UPD_FIFO_DEPTH > 1) ? $clog2(UPD_FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StRun, StFlush} state_e;

   state_e state_q, state_d;
   logic [3:0] flush_cnt_q, flush_cnt_d;

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic [31:0] pc_mem     [UPD_FIFO_DEPTH];
   logic        taken_mem  [UPD_FIFO_DEPTH];
   logic [31:0] target_mem [UPD_FIFO_DEPTH];

   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

   logic ready;
   logic accept;
   logic br_accept;
   logic mispredict;
   logic mis_accept;
   logic head_valid;
   logic push;
   logic pop;

   // Mispredict covers both a wrong direction and a wrong target on a taken branch.
   always_comb begin
      mispredict = (res_pred_taken_i != res_actual_taken_i) ||
                   (res_pred_taken_i && res_actual_taken_i &&
                    (res_pred_target_i != res_actual_target_i));
   end

   always_comb begin
      ready      = (state_q == StFlush) ? 1'b1 : (count_q < CntW'(UPD_FIFO_DEPTH));
      accept     = res_valid_i && ready;
      br_accept  = accept && (state_q == StRun) && res_is_branch_i;
      mis_accept = br_accept && mispredict;
      head_valid = (count_q != '0);
      push       = br_accept;
      pop        = head_valid && !upd_stall_i;
   end

   // FSM: the flush window length is counted down from FLUSH_CYCLES on entry.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         StRun: begin
            if (mis_accept) begin
               state_d     = StFlush;
               flush_cnt_d = 4'(FLUSH_CYCLES);
            end
         end
         StFlush: begin
            flush_cnt_d = flush_cnt_q - 4'd1;
            if (flush_cnt_q <= 4'd1) begin
               state_d     = StRun;
               flush_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d     = StRun;
            flush_cnt_d = 4'd0;
         end
      endcase
   end

   always_comb begin
      redirect_d    = mis_accept;
      redirect_pc_d = '0;
      if (mis_accept) begin
         redirect_pc_d = res_actual_taken_i ? res_actual_target_i : (res_pc_i + 32'd4);
      end
   end

   always_comb begin
      wr_ptr_d = push ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Clear wins over a same-cycle increment; both counters stick at all-ones.
   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (cnt_clear_i) begin
         branch_cnt_d     = '0;
         mispredict_cnt_d = '0;
      end else begin
         if (push && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
         end
         if (mis_accept && !(&mispredict_cnt_q)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q          <= StRun;
         flush_cnt_q      <= 4'd0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         redirect_q       <= 1'b0;
         redirect_pc_q    <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         state_q          <= state_d;
         flush_cnt_q      <= flush_cnt_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         redirect_q       <= redirect_d;
         redirect_pc_q    <= redirect_pc_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the queue is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[wr_ptr_q]     <= res_pc_i;
         taken_mem[wr_ptr_q]  <= res_actual_taken_i;
         target_mem[wr_ptr_q] <= res_actual_target_i;
      end
   end

   always_comb begin
      res_ready_o      = ready;
      redirect_o       = redirect_q;
      redirect_pc_o    = redirect_pc_q;
      update_o         = pop;
      is_branch_o      = pop;
      update_pc_o      = head_valid ? pc_mem[rd_ptr_q] : '0;
      actual_taken_o   = head_valid ? taken_mem[rd_ptr_q] : 1'b0;
      actual_target_o  = head_valid ? target_mem[rd_ptr_q] : '0;
      branch_cnt_o     = branch_cnt_q;
      mispredict_cnt_o = mispredict_cnt_q;
   end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed self-checking bench for branch_resolution_unit (depth 4, flush 2, 4-bit counters).
module tb_branch_resolution_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        res_valid_i = 1'b0;
   logic        res_ready_o;
   logic [31:0] res_pc_i = '0;
   logic        res_is_branch_i = 1'b0;
   logic        res_pred_taken_i = 1'b0;
   logic [31:0] res_pred_target_i = '0;
   logic        res_actual_taken_i = 1'b0;
   logic [31:0] res_actual_target_i = '0;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        upd_stall_i = 1'b0;
   logic        update_o;
   logic [31:0] update_pc_o;
   logic        actual_taken_o;
   logic [31:0] actual_target_o;
   logic        is_branch_o;
   logic        cnt_clear_i = 1'b0;
   logic [3:0]  branch_cnt_o;
   logic [3:0]  mispredict_cnt_o;

   int checks = 0;
   int errors = 0;

   branch_resolution_unit #(
      .UPD_FIFO_DEPTH(4),
      .FLUSH_CYCLES  (2),
      .CNT_WIDTH     (4)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .res_valid_i        (res_valid_i),
      .res_ready_o        (res_ready_o),
      .res_pc_i           (res_pc_i),
      .res_is_branch_i    (res_is_branch_i),
      .res_pred_taken_i   (res_pred_taken_i),
      .res_pred_target_i  (res_pred_target_i),
      .res_actual_taken_i (res_actual_taken_i),
      .res_actual_target_i(res_actual_target_i),
      .redirect_o         (redirect_o),
      .redirect_pc_o      (redirect_pc_o),
      .upd_stall_i        (upd_stall_i),
      .update_o           (update_o),
      .update_pc_o        (update_pc_o),
      .actual_taken_o     (actual_taken_o),
      .actual_target_o    (actual_target_o),
      .is_branch_o        (is_branch_o),
      .cnt_clear_i        (cnt_clear_i),
      .branch_cnt_o       (branch_cnt_o),
      .mispredict_cnt_o   (mispredict_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic br, input logic pt,
                        input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
      res_valid_i         = 1'b1;
      res_pc_i            = pc;
      res_is_branch_i     = br;
      res_pred_taken_i    = pt;
      res_pred_target_i   = ptgt;
      res_actual_taken_i  = at;
      res_actual_target_i = atgt;
   endtask

   task automatic idle();
      res_valid_i     = 1'b0;
      res_is_branch_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      upd_stall_i = 1'b0;
      cnt_clear_i = 1'b0;
      idle();
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({redirect_o, update_o, is_branch_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_pulses: got %b want 000", {redirect_o, update_o, is_branch_o});
      end
      checks++;
      if ({redirect_pc_o, update_pc_o, actual_target_o} !== 96'd0) begin
         errors++;
         $display("FAIL reset_addr: got %h %h %h want 0", redirect_pc_o, update_pc_o,
                  actual_target_o);
      end
      checks++;
      if ({branch_cnt_o, mispredict_cnt_o} !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d %0d want 0 0", branch_cnt_o, mispredict_cnt_o);
      end
      step();
      rst_i = 1'b0;
      step();
      checks++;
      if (res_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", res_ready_o);
      end
   endtask

   task automatic test_correct();
      do_reset();
      // Non-branch with mismatching prediction must be dropped silently.
      drive(32'h80, 1'b0, 1'b0, 32'h0, 1'b1, 32'h999);
      step();
      idle();
      checks++;
      if ({redirect_o, update_o, branch_cnt_o, mispredict_cnt_o} !== 10'd0) begin
         errors++;
         $display("FAIL non_branch: got redir=%b upd=%b cnt=%0d/%0d want all 0", redirect_o,
                  update_o, branch_cnt_o, mispredict_cnt_o);
      end
      drive(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
      step();
      idle();
      checks++;
      if (redirect_o !== 1'b0) begin
         errors++;
         $display("FAIL correct_redirect: got %b want 0", redirect_o);
      end
      checks++;
      if ({update_o, is_branch_o, update_pc_o, actual_taken_o, actual_target_o} !==
          {1'b1, 1'b1, 32'h100, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL correct_update: got upd=%b br=%b pc=%h t=%b tgt=%h want 1 1 100 1 200",
                  update_o, is_branch_o, update_pc_o, actual_taken_o, actual_target_o);
      end
      checks++;
      if ({branch_cnt_o, mispredict_cnt_o} !== {4'd1, 4'd0}) begin
         errors++;
         $display("FAIL correct_cnt: got %0d/%0d want 1/0", branch_cnt_o, mispredict_cnt_o);
      end
      step();
      checks++;
      if (update_o !== 1'b0) begin
         errors++;
         $display("FAIL correct_pop: got update %b want 0", update_o);
      end
   endtask

   task automatic test_dir_mispredict();
      do_reset();
      drive(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
      step();
      checks++;
      if ({redirect_o, redirect_pc_o, mispredict_cnt_o} !== {1'b1, 32'h400, 4'd1}) begin
         errors++;
         $display("FAIL dir_redirect: got %b %h cnt=%0d want 1 400 1", redirect_o,
                  redirect_pc_o, mispredict_cnt_o);
      end
      drive(32'h500, 1'b1, 1'b0, 32'h0, 1'b1, 32'h600);
      step();
      checks++;
      if ({redirect_o, update_o} !== 2'b00) begin
         errors++;
         $display("FAIL dir_discard1: got redir=%b upd=%b want 0 0", redirect_o, update_o);
      end
      drive(32'h540, 1'b1, 1'b0, 32'h0, 1'b1, 32'h640);
      step();
      checks++;
      if ({redirect_o, update_o, branch_cnt_o} !== {1'b0, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL dir_discard2: got redir=%b upd=%b bcnt=%0d want 0 0 1", redirect_o,
                  update_o, branch_cnt_o);
      end
      drive(32'h700, 1'b1, 1'b1, 32'h800, 1'b1, 32'h800);
      step();
      idle();
      checks++;
      if ({update_o, update_pc_o, branch_cnt_o, mispredict_cnt_o} !==
          {1'b1, 32'h700, 4'd2, 4'd1}) begin
         errors++;
         $display("FAIL dir_third: got upd=%b pc=%h cnt=%0d/%0d want 1 700 2/1", update_o,
                  update_pc_o, branch_cnt_o, mispredict_cnt_o);
      end
   endtask

   task automatic test_target_wrap();
      do_reset();
      drive(32'h1000, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
      step();
      idle();
      checks++;
      if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h300}) begin
         errors++;
         $display("FAIL target_redirect: got %b %h want 1 300", redirect_o, redirect_pc_o);
      end
      step();
      step();
      drive(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10, 1'b0, 32'h1234);
      step();
      idle();
      checks++;
      if ({redirect_o, redirect_pc_o, mispredict_cnt_o} !== {1'b1, 32'h0, 4'd2}) begin
         errors++;
         $display("FAIL wrap_redirect: got %b %h cnt=%0d want 1 00000000 2", redirect_o,
                  redirect_pc_o, mispredict_cnt_o);
      end
   endtask

   task automatic test_backpressure();
      logic exp_ready;
      do_reset();
      upd_stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(32'h2000 + 32'(i * 16), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         exp_ready = (i < 4);
         checks++;
         if (res_ready_o !== exp_ready) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %b want %b", i, res_ready_o, exp_ready);
         end
         step();
      end
      idle();
      checks++;
      if ({update_o, branch_cnt_o} !== {1'b0, 4'd4}) begin
         errors++;
         $display("FAIL bp_stalled: got upd=%b bcnt=%0d want 0 4", update_o, branch_cnt_o);
      end
      upd_stall_i = 1'b0;
      drive(32'h2F00, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (res_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_full_pop_ready: got %b want 0", res_ready_o);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({update_o, update_pc_o} !== {1'b1, 32'h2000 + 32'(i * 16)}) begin
            errors++;
            $display("FAIL bp_drain[%0d]: got %b %h want 1 %h", i, update_o, update_pc_o,
                     32'h2000 + 32'(i * 16));
         end
         step();
         idle();
      end
      checks++;
      if ({update_o, branch_cnt_o} !== {1'b0, 4'd4}) begin
         errors++;
         $display("FAIL bp_empty: got upd=%b bcnt=%0d want 0 4", update_o, branch_cnt_o);
      end
   endtask

   task automatic test_counters();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(32'h4000 + 32'(i * 4), 1'b1, 1'b1, 32'h50, 1'b1, 32'h50);
         step();
         if (i == 14) begin
            checks++;
            if (branch_cnt_o !== 4'd15) begin
               errors++;
               $display("FAIL cnt_reach15: got %0d want 15", branch_cnt_o);
            end
         end
      end
      checks++;
      if (branch_cnt_o !== 4'd15) begin
         errors++;
         $display("FAIL cnt_saturate: got %0d want 15", branch_cnt_o);
      end
      drive(32'h5000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5100);
      cnt_clear_i = 1'b1;
      step();
      idle();
      cnt_clear_i = 1'b0;
      checks++;
      if ({redirect_o, branch_cnt_o, mispredict_cnt_o} !== {1'b1, 4'd0, 4'd0}) begin
         errors++;
         $display("FAIL cnt_clear_prio: got redir=%b cnt=%0d/%0d want 1 0/0", redirect_o,
                  branch_cnt_o, mispredict_cnt_o);
      end
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      upd_stall_i = 1'b1;
      drive(32'h6000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      drive(32'h6004, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      drive(32'h6008, 1'b1, 1'b0, 32'h0, 1'b1, 32'h6100);
      step();
      idle();
      checks++;
      if ({redirect_o, branch_cnt_o} !== {1'b1, 4'd3}) begin
         errors++;
         $display("FAIL rmf_setup: got redir=%b bcnt=%0d want 1 3", redirect_o, branch_cnt_o);
      end
      upd_stall_i = 1'b0;
      rst_i       = 1'b1;
      #1;
      checks++;
      if ({redirect_o, update_o, is_branch_o, redirect_pc_o, update_pc_o, branch_cnt_o,
           mispredict_cnt_o} !== 75'd0) begin
         errors++;
         $display("FAIL rmf_immediate: got %b %b %b %h %h %0d %0d want all 0", redirect_o,
                  update_o, is_branch_o, redirect_pc_o, update_pc_o, branch_cnt_o,
                  mispredict_cnt_o);
      end
      step();
      step();
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (update_o !== 1'b0) begin
            errors++;
            $display("FAIL rmf_no_update[%0d]: got %b want 0", i, update_o);
         end
         step();
      end
      drive(32'h7000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h7100);
      step();
      idle();
      checks++;
      if ({redirect_o, redirect_pc_o, update_o, update_pc_o} !==
          {1'b1, 32'h7100, 1'b1, 32'h7000}) begin
         errors++;
         $display("FAIL rmf_first: got redir=%b %h upd=%b %h want 1 7100 1 7000", redirect_o,
                  redirect_pc_o, update_o, update_pc_o);
      end
   endtask

   initial begin
      test_reset();
      test_correct();
      test_dir_mispredict();
      test_target_wrap();
      test_backpressure();
      test_counters();
      test_reset_mid_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
